// File: rtl/picorv_cache_bridge.sv
// Bridges the PicoRV native memory interface onto a valid/ready cache request
// port with a single outstanding request, response timeout and sticky error flag.
module picorv_cache_bridge #(
    parameter logic [31:0] PhysMemLimit  = 32'h0002_0000,
    parameter int          OffsetWidth   = 12,
    parameter int          TagWidth      = 20,
    parameter int          TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic                   mem_valid_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            mem_wdata_i,
    input  logic [3:0]             mem_wstrb_i,
    output logic                   mem_ready_o,
    output logic [31:0]            mem_rdata_o,

    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [OffsetWidth-1:0] req_addr_offset_o,
    output logic [TagWidth-1:0]    req_addr_tag_o,
    output logic [31:0]            req_wdata_o,
    output logic [3:0]             req_be_o,
    output logic                   req_store_o,
    output logic                   req_uncacheable_o,

    input  logic                   rsp_valid_i,
    input  logic [31:0]            rsp_rdata_i,
    input  logic                   rsp_error_i,
    output logic                   error_o,
    output logic                   busy_o
);

    localparam int CountWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  store_q;
    logic                  uncacheable_q;
    logic [CountWidth-1:0] wait_count;

    assign req_addr_offset_o = addr_q[OffsetWidth-1:0];
    assign req_addr_tag_o    = addr_q[31:32-TagWidth];
    assign req_wdata_o       = wdata_q;
    assign req_be_o          = wstrb_q;
    assign req_store_o       = store_q;
    assign req_uncacheable_o = uncacheable_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            store_q       <= 1'b0;
            uncacheable_q <= 1'b0;
            wait_count    <= '0;
            mem_ready_o   <= 1'b0;
            mem_rdata_o   <= '0;
            req_valid_o   <= 1'b0;
            error_o       <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            mem_ready_o <= 1'b0;

            // A response with nothing outstanding is a protocol violation.
            if (rsp_valid_i && (state != ST_WAIT)) begin
                error_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (mem_valid_i) begin
                        addr_q        <= mem_addr_i;
                        wdata_q       <= mem_wdata_i;
                        wstrb_q       <= mem_wstrb_i;
                        store_q       <= |mem_wstrb_i;
                        uncacheable_q <= (mem_addr_i > PhysMemLimit);
                        req_valid_o   <= 1'b1;
                        busy_o        <= 1'b1;
                        state         <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (req_ready_i) begin
                        req_valid_o <= 1'b0;
                        wait_count  <= '0;
                        state       <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (rsp_valid_i) begin
                        mem_rdata_o <= rsp_rdata_i;
                        if (rsp_error_i) begin
                            error_o <= 1'b1;
                        end
                        mem_ready_o <= 1'b1;
                        state       <= ST_DONE;
                    end else if (wait_count == CountLast) begin
                        // Give the core a recognisable poison value rather than hanging it.
                        mem_rdata_o <= 32'hDEAD_BEEF;
                        error_o     <= 1'b1;
                        mem_ready_o <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end

                ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    req_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv_cache_bridge.sv
// Self-checking bench for picorv_cache_bridge: directed corner cases followed by
// randomized transactions checked against a cycle-count and value model.
module tb_picorv_cache_bridge;

    localparam int          TIMEOUT = 8;
    localparam logic [31:0] LIMIT   = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [11:0] req_offset;
    logic [19:0] req_tag;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_store;
    logic        req_uncacheable;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_error = 1'b0;
    logic        error;
    logic        busy;

    int tests = 0;
    int failed = 0;

    // Model state: sticky error and the last value the core was handed.
    bit          model_err = 1'b0;
    logic [31:0] last_rdata = '0;

    picorv_cache_bridge #(
        .PhysMemLimit (LIMIT),
        .OffsetWidth  (12),
        .TagWidth     (20),
        .TimeoutCycles(TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .mem_valid_i      (mem_valid),
        .mem_addr_i       (mem_addr),
        .mem_wdata_i      (mem_wdata),
        .mem_wstrb_i      (mem_wstrb),
        .mem_ready_o      (mem_ready),
        .mem_rdata_o      (mem_rdata),
        .req_valid_o      (req_valid),
        .req_ready_i      (req_ready),
        .req_addr_offset_o(req_offset),
        .req_addr_tag_o   (req_tag),
        .req_wdata_o      (req_wdata),
        .req_be_o         (req_be),
        .req_store_o      (req_store),
        .req_uncacheable_o(req_uncacheable),
        .rsp_valid_i      (rsp_valid),
        .rsp_rdata_i      (rsp_rdata),
        .rsp_error_i      (rsp_error),
        .error_o          (error),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_error"}, 32'(error), 32'(model_err));
        check({tag, "_rdata"}, mem_rdata, last_rdata);
    endtask

    task automatic do_reset();
        next_cycle();
        reset_i   = 1'b1;
        mem_valid = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        next_cycle();
        model_err  = 1'b0;
        last_rdata = '0;
        check_quiet_outputs("reset");
        reset_i = 1'b0;
    endtask

    // One complete transaction. Cycle 0 presents the request in IDLE; the model
    // predicts the mem_ready cycle purely from stall counts and the timeout rule.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int stalls, input int delay,
                           input bit timeout, input logic [31:0] rdata, input bit rerr);
        int          done_cycle;
        logic [31:0] exp_rdata;
        done_cycle = 2 + stalls + (timeout ? TIMEOUT : delay + 1);
        exp_rdata  = timeout ? 32'hDEAD_BEEF : rdata;

        next_cycle();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mem_ready", 32'(mem_ready), 32'd0);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        for (int c = 1; c <= done_cycle; c++) begin
            next_cycle();
            // Core-side noise while busy must not disturb the captured request.
            mem_valid = 1'($urandom);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
            req_ready = (c == 1 + stalls) ? 1'b1 : ((c > 1 + stalls) ? 1'($urandom) : 1'b0);
            rsp_valid = !timeout && (c == 2 + stalls + delay);
            rsp_rdata = rsp_valid ? rdata : $urandom;
            rsp_error = rsp_valid ? rerr : 1'($urandom);

            check("busy", 32'(busy), 32'd1);
            check("req_valid", 32'(req_valid), 32'(c <= 1 + stalls));
            if (c <= 1 + stalls) begin
                check("req_offset", 32'(req_offset), addr % 32'h1000);
                check("req_tag", 32'(req_tag), addr / 32'h1000);
                check("req_wdata", req_wdata, wdata);
                check("req_be", 32'(req_be), 32'(wstrb));
                check("req_store", 32'(req_store), 32'(wstrb != 4'd0));
                check("req_uncacheable", 32'(req_uncacheable), 32'(addr > LIMIT));
            end
            check("mem_ready", 32'(mem_ready), 32'(c == done_cycle));
            if (c == done_cycle) begin
                model_err  = model_err | timeout | (!timeout && rerr);
                last_rdata = exp_rdata;
                check("done_rdata", mem_rdata, last_rdata);
                check("done_error", 32'(error), 32'(model_err));
            end else begin
                check("rdata_hold", mem_rdata, last_rdata);
            end
        end
        mem_valid = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        logic [3:0]  wstrb;
        int          pick;
        bit          tmo;

        repeat (2) next_cycle();
        check_quiet_outputs("por");
        reset_i = 1'b0;

        // Plain load with immediate handshake: mem_ready in cycle 3.
        run_txn(32'h0000_1234, 32'h0, 4'b0000, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
        // Uncacheable byte store with three ready stalls.
        run_txn(32'h1000_0000, 32'h41, 4'b0001, 3, 1, 1'b0, 32'h0BAD_0001, 1'b0);
        // Cacheability boundary.
        run_txn(32'h0002_0000, 32'h0, 4'b0000, 0, 2, 1'b0, 32'h1357_9BDF, 1'b0);
        run_txn(32'h0002_0001, 32'h0, 4'b0000, 1, 0, 1'b0, 32'h2468_ACE0, 1'b0);
        // Timeout, then a normal transaction with error still set.
        run_txn(32'h0000_0100, 32'h0, 4'b0000, 0, 0, 1'b1, 32'h0, 1'b0);
        run_txn(32'h0000_0200, 32'h5555_AAAA, 4'b1111, 0, 0, 1'b0, 32'h7777_8888, 1'b0);

        // Reset while in WAIT, then a stray response on the first cycle after reset.
        next_cycle();
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0040;
        mem_wstrb = 4'b0000;
        next_cycle();
        mem_valid = 1'b0;
        check("rw_req_valid", 32'(req_valid), 32'd1);
        req_ready = 1'b1;
        next_cycle();
        req_ready = 1'b0;
        check("rw_in_wait", 32'(busy), 32'd1);
        reset_i = 1'b1;
        next_cycle();
        reset_i    = 1'b0;
        model_err  = 1'b0;
        last_rdata = '0;
        check_quiet_outputs("rw_after_reset");
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1111_2222;
        next_cycle();
        rsp_valid = 1'b0;
        model_err = 1'b1;
        check_quiet_outputs("rw_stray_rsp");
        next_cycle();
        check_quiet_outputs("rw_no_pulse");

        // Reset while in REQ drops req_valid on the next cycle.
        next_cycle();
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0080;
        next_cycle();
        mem_valid = 1'b0;
        check("rr_req_valid", 32'(req_valid), 32'd1);
        reset_i = 1'b1;
        next_cycle();
        reset_i    = 1'b0;
        model_err  = 1'b0;
        last_rdata = '0;
        check_quiet_outputs("rr_after_reset");
        next_cycle();
        check_quiet_outputs("rr_no_pulse");

        // Randomized traffic, mostly back-to-back, sometimes with idle gaps.
        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       addr = LIMIT;
                1:       addr = LIMIT + 32'd1;
                2:       addr = $urandom_range(0, 32'h0002_0000);
                default: addr = $urandom;
            endcase
            wstrb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            tmo   = ($urandom_range(0, 4) == 0);
            run_txn(addr, $urandom, wstrb, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, TIMEOUT - 1)), tmo, $urandom,
                    ($urandom_range(0, 7) == 0));
            repeat (int'($urandom_range(0, 1))) begin
                next_cycle();
                check_quiet_outputs("gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
